// File: rtl/uart_arb_pkg.sv
// Shared types and widths for the UART transmitter arbiter and its
// round-robin picker.
package uart_arb_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 8;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    // Counters stop at MAX_BURST / IDLE_TIMEOUT (both <= 255), so a plain increment never wraps.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] value);
        return value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// rr_ptr+1, wrapping modulo NUM_REQ, as both one-hot and index.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               any_req
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;
    logic             hit_s;
    logic             found_s;

    assign any_req = |req;

    // Walk candidates in priority order; the first requesting one wins.
    always_comb begin
        pick     = {NUM_REQ{1'b0}};
        pick_idx = {IDX_W{1'b0}};
        sum_s    = {(IDX_W+1){1'b0}};
        cand_s   = {IDX_W{1'b0}};
        hit_s    = 1'b0;
        found_s  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum_s  = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            cand_s = (sum_s >= (IDX_W+1)'(NUM_REQ)) ?
                     IDX_W'(sum_s - (IDX_W+1)'(NUM_REQ)) : sum_s[IDX_W-1:0];
            hit_s            = req[cand_s] & ~found_s;
            pick[cand_s]     = pick[cand_s] | hit_s;
            pick_idx         = hit_s ? cand_s : pick_idx;
            found_s          = found_s | hit_s;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams;
// a grant lasts for a whole message. Define UART_TX_ARB_IDLE_RELEASE_EN to
// release an owner that stays idle for IDLE_TIMEOUT cycles.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255 ||
        IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 255) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    arb_state_e          state_r, state_next_s;
    logic [NUM_REQ-1:0]  grant_r, grant_next_s;
    logic [IDX_W-1:0]    owner_r, owner_next_s;
    logic [IDX_W-1:0]    rr_ptr_r, rr_ptr_next_s;
    logic [CNT_W-1:0]    burst_cnt_r, burst_cnt_next_s;
    logic [CNT_W-1:0]    burst_inc_s;
    logic [BYTE_W-1:0]   byte_s [NUM_REQ];
    logic [NUM_REQ-1:0]  pick_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic                any_req_s;
    logic                own_valid_s;
    logic                own_last_s;
    logic                handshake_s;
    logic                idle_expire_s;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
        assign byte_s[i] = req_data[i*BYTE_W +: BYTE_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req      (req_valid),
        .rr_ptr   (rr_ptr_r),
        .pick     (pick_s),
        .pick_idx (pick_idx_s),
        .any_req  (any_req_s)
    );

    // grant_r is all-zero outside OWN, so masking with it gates every output.
    assign own_valid_s = |(grant_r & req_valid);
    assign own_last_s  = |(grant_r & req_last);
    assign handshake_s = own_valid_s & tx_ready;
    assign burst_inc_s = cnt_inc(burst_cnt_r);

    assign tx_valid  = own_valid_s;
    assign req_ready = grant_r & {NUM_REQ{tx_ready}};
    assign grant     = grant_r;
    assign busy      = (state_r == ARB_OWN);

    // Data mux from the current owner; quiet zero while idle or in reset.
    always_comb begin
        tx_data = {BYTE_W{1'b0}};
        if (state_r == ARB_OWN) begin
            tx_data = byte_s[owner_r];
        end else begin
            tx_data = {BYTE_W{1'b0}};
        end
    end

`ifdef UART_TX_ARB_IDLE_RELEASE_EN
    logic [CNT_W-1:0] idle_cnt_r, idle_cnt_next_s;

    // Count consecutive owned cycles with the owner's valid low.
    always_comb begin
        idle_cnt_next_s = {CNT_W{1'b0}};
        idle_expire_s   = 1'b0;
        if (state_r == ARB_OWN && !own_valid_s) begin
            idle_expire_s   = (cnt_inc(idle_cnt_r) == CNT_W'(IDLE_TIMEOUT));
            idle_cnt_next_s = idle_expire_s ? {CNT_W{1'b0}} : cnt_inc(idle_cnt_r);
        end else begin
            idle_cnt_next_s = {CNT_W{1'b0}};
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= {CNT_W{1'b0}};
        end else begin
            idle_cnt_r <= idle_cnt_next_s;
        end
    end
`else
    assign idle_expire_s = 1'b0;
`endif

    // Next grant/control state; a release always passes through one IDLE cycle.
    always_comb begin
        state_next_s     = state_r;
        grant_next_s     = grant_r;
        owner_next_s     = owner_r;
        rr_ptr_next_s    = rr_ptr_r;
        burst_cnt_next_s = burst_cnt_r;
        case (state_r)
            ARB_IDLE: begin
                burst_cnt_next_s = {CNT_W{1'b0}};
                if (any_req_s) begin
                    state_next_s = ARB_OWN;
                    grant_next_s = pick_s;
                    owner_next_s = pick_idx_s;
                end else begin
                    state_next_s = ARB_IDLE;
                    grant_next_s = {NUM_REQ{1'b0}};
                end
            end
            ARB_OWN: begin
                if (handshake_s) begin
                    burst_cnt_next_s = burst_inc_s;
                    if (own_last_s || burst_inc_s == CNT_W'(MAX_BURST)) begin
                        state_next_s     = ARB_IDLE;
                        grant_next_s     = {NUM_REQ{1'b0}};
                        rr_ptr_next_s    = owner_r;
                        burst_cnt_next_s = {CNT_W{1'b0}};
                    end else begin
                        state_next_s = ARB_OWN;
                    end
                end else if (idle_expire_s) begin
                    state_next_s     = ARB_IDLE;
                    grant_next_s     = {NUM_REQ{1'b0}};
                    rr_ptr_next_s    = owner_r;
                    burst_cnt_next_s = {CNT_W{1'b0}};
                end else begin
                    state_next_s = ARB_OWN;
                end
            end
            default: begin
                state_next_s     = ARB_IDLE;
                grant_next_s     = {NUM_REQ{1'b0}};
                burst_cnt_next_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // Grant and control registers; reset leaves requester 0 at top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ARB_IDLE;
            grant_r     <= {NUM_REQ{1'b0}};
            owner_r     <= {IDX_W{1'b0}};
            rr_ptr_r    <= IDX_W'(NUM_REQ - 1);
            burst_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_next_s;
            grant_r     <= grant_next_s;
            owner_r     <= owner_next_s;
            rr_ptr_r    <= rr_ptr_next_s;
            burst_cnt_r <= burst_cnt_next_s;
        end
    end

endmodule
